matbi_watch_ctrl: RTL

// - Parametrised watch/timer core: internal prescaler turns i_freq clk cycles into one-second ticks.
// - Counts hh:mm:ss up (clock mode) or down (countdown timer mode).
// - Adds a synchronous time-load port, an alarm comparator and a timer-expired indication.
// - Sits between board I/O (buttons/switches via the config regs) and the 7-seg/display formatter.

---
 rtl/matbi_watch_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/matbi_watch_ctrl.sv
// matbi_watch_ctrl: hh:mm:ss watch / countdown-timer core.
//   A prescaler divides clk by i_freq to produce one-second ticks. Each tick
//   advances the time (i_mode=0) or decrements it (i_mode=1). In timer mode,
//   reaching 00:00:00 parks the core in ST_DONE and pulses o_done.
//   A load strobe sets the time with clamping. An alarm comparator pulses
//   o_alarm once per matching time update.
// Ports:
//   clk, reset (async, active low)
//   i_run_en, i_freq, i_mode            run control / prescaler divisor / direction
//   i_load, i_load_{sec,min,hour}       synchronous time load (clamped)
//   i_alarm_en, i_alarm_{sec,min,hour}  alarm compare
//   o_sec, o_min, o_hour                current time
//   o_tick, o_alarm, o_done             single-cycle event pulses
module matbi_watch_ctrl #(
    parameter int P_COUNT_BIT = 30,
    parameter int P_SEC_BIT   = 6,
    parameter int P_MIN_BIT   = 6,
    parameter int P_HOUR_BIT  = 5,
    parameter int P_HOUR_MAX  = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_run_en,
    input  logic [P_COUNT_BIT-1:0] i_freq,
    input  logic                   i_mode,
    input  logic                   i_load,
    input  logic [P_SEC_BIT-1:0]   i_load_sec,
    input  logic [P_MIN_BIT-1:0]   i_load_min,
    input  logic [P_HOUR_BIT-1:0]  i_load_hour,
    input  logic                   i_alarm_en,
    input  logic [P_SEC_BIT-1:0]   i_alarm_sec,
    input  logic [P_MIN_BIT-1:0]   i_alarm_min,
    input  logic [P_HOUR_BIT-1:0]  i_alarm_hour,
    output logic [P_SEC_BIT-1:0]   o_sec,
    output logic [P_MIN_BIT-1:0]   o_min,
    output logic [P_HOUR_BIT-1:0]  o_hour,
    output logic                   o_tick,
    output logic                   o_alarm,
    output logic                   o_done
);

    localparam logic [P_SEC_BIT-1:0]  SEC_TOP  = P_SEC_BIT'(59);
    localparam logic [P_MIN_BIT-1:0]  MIN_TOP  = P_MIN_BIT'(59);
    localparam logic [P_HOUR_BIT-1:0] HOUR_TOP = P_HOUR_BIT'(P_HOUR_MAX - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                 state;
    logic [P_COUNT_BIT-1:0] r_cnt;
    logic                   r_upd;   // time registers were written on the last edge

    logic                   count_en, tick, time_zero, dn_zero, alarm_hit;
    logic [P_SEC_BIT-1:0]   up_sec, dn_sec, ld_sec;
    logic [P_MIN_BIT-1:0]   up_min, dn_min, ld_min;
    logic [P_HOUR_BIT-1:0]  up_hour, dn_hour, ld_hour;

    // ST_IDLE with i_run_en high is the entry cycle into ST_RUN; it already
    // counts so a resumed second is not stretched by one clock.
    assign count_en  = i_run_en && (state != ST_DONE);
    assign tick      = count_en && ((i_freq <= P_COUNT_BIT'(1)) ||
                                    (r_cnt >= i_freq - P_COUNT_BIT'(1)));
    assign time_zero = (o_sec == '0) && (o_min == '0) && (o_hour == '0);
    assign dn_zero   = (o_sec == P_SEC_BIT'(1)) && (o_min == '0) && (o_hour == '0);
    assign alarm_hit = (o_sec == i_alarm_sec) && (o_min == i_alarm_min) &&
                       (o_hour == i_alarm_hour);

    assign ld_sec  = (i_load_sec  > SEC_TOP)  ? SEC_TOP  : i_load_sec;
    assign ld_min  = (i_load_min  > MIN_TOP)  ? MIN_TOP  : i_load_min;
    assign ld_hour = (i_load_hour > HOUR_TOP) ? HOUR_TOP : i_load_hour;

    always_comb begin
        up_sec  = o_sec + P_SEC_BIT'(1);
        up_min  = o_min;
        up_hour = o_hour;
        if (o_sec >= SEC_TOP) begin
            up_sec = '0;
            if (o_min >= MIN_TOP) begin
                up_min  = '0;
                up_hour = (o_hour >= HOUR_TOP) ? '0 : o_hour + P_HOUR_BIT'(1);
            end else begin
                up_min = o_min + P_MIN_BIT'(1);
            end
        end
    end

    // Only used when the time is nonzero, so the hour borrow cannot underflow.
    always_comb begin
        dn_sec  = o_sec - P_SEC_BIT'(1);
        dn_min  = o_min;
        dn_hour = o_hour;
        if (o_sec == '0) begin
            dn_sec = SEC_TOP;
            if (o_min == '0) begin
                dn_min  = MIN_TOP;
                dn_hour = o_hour - P_HOUR_BIT'(1);
            end else begin
                dn_min = o_min - P_MIN_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            r_cnt   <= '0;
            r_upd   <= 1'b0;
            o_sec   <= '0;
            o_min   <= '0;
            o_hour  <= '0;
            o_tick  <= 1'b0;
            o_alarm <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_tick  <= 1'b0;
            o_done  <= 1'b0;
            r_upd   <= 1'b0;
            // Compare after the update has landed, so the pulse follows the change.
            o_alarm <= r_upd && i_alarm_en && alarm_hit;

            case (state)
                ST_IDLE: if (i_run_en) state <= ST_RUN;
                ST_RUN:  if (!i_run_en) state <= ST_IDLE;
                default: begin
                    if (!i_run_en)    state <= ST_IDLE;
                    else if (!i_mode) state <= ST_RUN;
                end
            endcase

            if (i_load) begin
                // Load wins over a same-cycle tick and restarts the second.
                o_sec  <= ld_sec;
                o_min  <= ld_min;
                o_hour <= ld_hour;
                r_cnt  <= '0;
                r_upd  <= 1'b1;
                state  <= i_run_en ? ST_RUN : ST_IDLE;
            end else begin
                if (count_en)
                    r_cnt <= tick ? '0 : r_cnt + P_COUNT_BIT'(1);
                if (tick) begin
                    if (!i_mode) begin
                        o_sec  <= up_sec;
                        o_min  <= up_min;
                        o_hour <= up_hour;
                        o_tick <= 1'b1;
                        r_upd  <= 1'b1;
                    end else if (time_zero) begin
                        state  <= ST_DONE;
                        o_done <= 1'b1;
                    end else begin
                        o_sec  <= dn_sec;
                        o_min  <= dn_min;
                        o_hour <= dn_hour;
                        o_tick <= 1'b1;
                        r_upd  <= 1'b1;
                        if (dn_zero) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
